enemy_spawn_sequencer: RTL

Game-flow controller sitting between the tick dividers, the LFSR random bits and the two `Enemy` slot instances. It owns the run/crash state, chooses which slot and lane receives each new enemy, retires enemies that leave the screen, ramps the enemy fall-rate accelerator, and keeps a pass counter. It replaces the ad-hoc spawn logic in the top level with one synchronous FSM clocked on the 50 MHz system clock.

---
 rtl/enemy_spawn_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/enemy_spawn_sequencer.sv
// Spawn/retire/crash sequencer for the two enemy slots.
// Clock clk50mhz, sync active-high reset; optional score via ENEMY_SPAWN_SEQ_SCORE_EN.
//
// Ports:
//   clk50mhz, reset         system clock, synchronous active-high reset
//   start                   level, leaves IDLE
//   spawn_tick              spawn strobe, rising-edge detected internally
//   collision               level, RUN -> CRASH
//   rnd[2:0]                random bits, rnd[1:0] selects the lane
//   enemy_y0/1[9:0]         current slot y positions
//   enable0/1, load0/1      slot active, one-cycle latch strobe
//   pos_x0/1, pos_y0/1      x/y presented with load
//   accel[24:0]             enemy fall-rate accelerator
//   score[9:0]              enemies passed (0 when the score macro is undefined)
//   crashed                 high in CRASH
module enemy_spawn_sequencer #(
  parameter int LANE_L       = 197,
  parameter int LANE_C       = 279,
  parameter int LANE_R       = 361,
  parameter int SPAWN_Y      = 0,
  parameter int PARK_Y       = 620,
  parameter int OFF_Y        = 600,
  parameter int GAP_Y        = 240,
  parameter int ACCEL_STEP   = 1000,
  parameter int ACCEL_MAX    = 99000,
  parameter int LEVEL_SPAWNS = 8
) (
  input  logic        clk50mhz,
  input  logic        reset,
  input  logic        start,
  input  logic        spawn_tick,
  input  logic        collision,
  input  logic [2:0]  rnd,
  input  logic [9:0]  enemy_y0,
  input  logic [9:0]  enemy_y1,
  output logic        enable0,
  output logic        enable1,
  output logic        load0,
  output logic        load1,
  output logic [9:0]  pos_x0,
  output logic [9:0]  pos_x1,
  output logic [9:0]  pos_y0,
  output logic [9:0]  pos_y1,
  output logic [24:0] accel,
  output logic [9:0]  score,
  output logic        crashed
);

  localparam logic [9:0]  XL = 10'(LANE_L);
  localparam logic [9:0]  XC = 10'(LANE_C);
  localparam logic [9:0]  XR = 10'(LANE_R);
  localparam logic [9:0]  SY = 10'(SPAWN_Y);
  localparam logic [9:0]  PY = 10'(PARK_Y);
  localparam logic [9:0]  OY = 10'(OFF_Y);
  localparam logic [9:0]  GY = 10'(GAP_Y);
  localparam logic [24:0] AST = 25'(ACCEL_STEP);
  localparam logic [24:0] AMX = 25'(ACCEL_MAX);
  localparam logic [15:0] LVL_LAST = 16'(LEVEL_SPAWNS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CRASH
  } state_t;

  state_t      state;
  logic        tick_q;
  logic [15:0] lvl_cnt;

  logic       tick_rise;
  logic       ret0, ret1;
  logic       lane_ok;
  logic [9:0] lane_x;
  logic       blk0, blk1;
  logic       spawn0, spawn1;
  logic       unused_rnd;

  assign unused_rnd = rnd[2];
  assign tick_rise  = spawn_tick & ~tick_q;
  assign ret0       = enable0 && (enemy_y0 >= OY);
  assign ret1       = enable1 && (enemy_y1 >= OY);

  always_comb begin
    lane_ok = 1'b1;
    lane_x  = XC;
    unique case (rnd[1:0])
      2'd0:    lane_x = XL;
      2'd1:    lane_x = XC;
      2'd2:    lane_x = XR;
      default: lane_ok = 1'b0;
    endcase
  end

  // Same-lane spawn only once the other enemy has fallen past the gap.
  assign blk0 = enable1 && (pos_x1 == lane_x)
             && (enemy_y1 < GY);
  assign blk1 = enable0 && (pos_x0 == lane_x)
             && (enemy_y0 < GY);

  // A retiring slot is still enabled, so !enable covers "free".
  assign spawn0 = tick_rise && lane_ok
               && !enable0 && !blk0;
  assign spawn1 = tick_rise && lane_ok
               && enable0 && !enable1 && !blk1;

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      state   <= IDLE;
      tick_q  <= 1'b0;
      lvl_cnt <= '0;
      enable0 <= 1'b0;
      enable1 <= 1'b0;
      load0   <= 1'b0;
      load1   <= 1'b0;
      pos_x0  <= XC;
      pos_x1  <= XC;
      pos_y0  <= PY;
      pos_y1  <= PY;
      accel   <= '0;
      crashed <= 1'b0;
    end else begin
      tick_q <= spawn_tick;
      load0  <= 1'b0;
      load1  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (collision) begin
            state   <= CRASH;
            crashed <= 1'b1;
          end else begin
            if (ret0) begin
              enable0 <= 1'b0;
              pos_y0  <= PY;
              load0   <= 1'b1;
            end
            if (ret1) begin
              enable1 <= 1'b0;
              pos_y1  <= PY;
              load1   <= 1'b1;
            end
            if (spawn0) begin
              enable0 <= 1'b1;
              pos_x0  <= lane_x;
              pos_y0  <= SY;
              load0   <= 1'b1;
            end
            if (spawn1) begin
              enable1 <= 1'b1;
              pos_x1  <= lane_x;
              pos_y1  <= SY;
              load1   <= 1'b1;
            end
            if (spawn0 || spawn1) begin
              if (lvl_cnt >= LVL_LAST) begin
                lvl_cnt <= '0;
                if (accel > AMX - AST) accel <= AMX;
                else                   accel <= accel + AST;
              end else begin
                lvl_cnt <= lvl_cnt + 16'd1;
              end
            end
          end
        end
        default: begin
          state <= CRASH;
        end
      endcase
    end
  end

`ifdef ENEMY_SPAWN_SEQ_SCORE_EN
  logic [9:0]  score_q;
  logic [10:0] sc_sum;

  assign sc_sum = {1'b0, score_q}
                + 11'(ret0) + 11'(ret1);
  assign score  = score_q;

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      score_q <= '0;
    end else if (state == RUN && !collision
                 && (ret0 || ret1)) begin
      if (sc_sum > 11'd999) score_q <= 10'd999;
      else                  score_q <= sc_sum[9:0];
    end
  end
`else
  assign score = '0;
`endif

endmodule
